aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Sequencing controller for the iterative AES-128 encryption datapath. It accepts one 128-bit block, performs the initial AddRoundKey, then drives the external round datapath for NR rounds. The round datapath is SubBytes -> ShiftRows -> MixColumns -> AddRoundKey, with MixColumns bypassed on the last round. It holds the running state register, supplies the round-key index to the key store, and returns the ciphertext over a valid/ready handshake.

Parameters:
NR, 10, number of rounds; legal 10/12/14.
DP_LATENCY, 1, cycles from dp_go to dp_result valid; legal 1..7.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset; asynchronous, active-low.
in_valid  in  1  input block offered.
in_ready  out  1  controller can accept a block.
data_in  in  128  plaintext block.
out_valid  out  1  ciphertext available.
out_ready  in  1  consumer accepts ciphertext.
data_out  out  128  ciphertext; equals the state register.
rk_in  in  128  round key for rnd_idx, from the key store; combinational, same cycle.
rnd_idx  out  4  round-key index requested.
dp_state  out  128  state presented to the round datapath (sub_bytes input).
dp_go  out  1  one-cycle pulse: round datapath launch.
dp_last  out  1  final round; datapath bypasses MixColumns.
dp_result  in  128  round datapath output after AddRoundKey.
busy  out  1  block in flight (states RUN or DONE).

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE. state_reg, round and cnt to 0. in_ready=0 for the reset cycle and 1 from the first edge after release. out_valid=0, dp_go=0, dp_last=0, busy=0, rnd_idx=0. Reset mid-block discards the block; no partial output is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, rnd_idx=0.
  - On in_valid: state_reg <= data_in ^ rk_in, round <= 1, cnt <= 0, go to RUN.
- RUN:
  - rnd_idx=round, dp_state=state_reg (stable for the whole round), dp_last=(round==NR).
  - dp_go=1 only when cnt==0.
  - cnt increments every cycle. When cnt==DP_LATENCY: state_reg <= dp_result, cnt <= 0.
    - If round==NR, go to DONE.
    - Otherwise round <= round+1 and stay in RUN.
  - Each round takes DP_LATENCY+1 cycles.
- DONE:
  - out_valid=1, data_out=state_reg.
  - On out_ready: go to IDLE, out_valid deasserts next cycle.
  - While out_ready=0, out_valid and data_out hold; no new block is accepted.
- Latency from in_valid&&in_ready to out_valid: 1+NR*(DP_LATENCY+1) cycles; 21 at the defaults.
- The DONE->IDLE transition costs one cycle. Back-to-back blocks are separated by at least one IDLE cycle.
- in_valid while busy: ignored, because in_ready=0.
- in_valid and out_ready both high in DONE: only the output handshake completes. The input is accepted in the following IDLE cycle.
- Counters: round is 4 bits, cnt is 3 bits. Neither wraps in legal operation.
- dp_state/rnd_idx outputs in IDLE and DONE are don't-care to the datapath but driven deterministically: dp_state=state_reg, rnd_idx=0 in IDLE, NR in DONE.

Optional Feature:
Macro: AES_CTRL_DECRYPT_EN.
- Defined:
  - Adds input port mode (1 bit), sampled on the accepted in_valid cycle and held in a register; 1 selects decrypt.
  - Adds output dp_inv, equal to the registered mode. It tells the datapath to use the inverse S-box, shift and mix.
  - Decrypt key order: whitening uses rnd_idx=NR; round r uses rnd_idx=NR-r, so the final round uses index 0.
  - dp_last, timing and handshake are unchanged from encrypt.
- Not defined: no mode or dp_inv ports; encrypt-only; logic is identical to mode=0.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f via key-store model, behavioural round model, block 00112233445566778899aabbccddeeff -> out_valid at cycle 21, data_out=69c4e0d86a7b0430d8cdb78070b4c55a; rnd_idx sequence 0,1..10; dp_last high only during round 10.
- Backpressure: hold out_ready=0 for 15 cycles after out_valid -> data_out stable, in_ready=0, new in_valid ignored; after release, the next block is accepted one cycle later.
- Latency sweep: DP_LATENCY=3 -> dp_go pulses exactly 10 times, 4 cycles apart; out_valid at cycle 41; same ciphertext.
- Reset mid-run: drop rst at round 5 -> outputs go to reset values asynchronously; the next block after release yields the correct ciphertext with no stale data.
- Back-to-back: in_valid held high with two blocks, out_ready=1 -> two correct ciphertexts, 22 cycles apart at the defaults.
- With AES_CTRL_DECRYPT_EN: mode=1, block 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff; rnd_idx sequence 10,9..0; dp_inv=1 for the whole block.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// ---------------------------------------------------------------------------
// Sequencing controller for an iterative AES datapath. A block accepted on
// the input handshake is whitened with round key 0 (the "initial AddRoundKey").
// The controller then drives the external round datapath for NR rounds. Each
// round lasts DP_LATENCY+1 cycles. The ciphertext is held in DONE until the
// consumer takes it.
//
// Optional feature: define AES_CTRL_DECRYPT_EN to add the mode input and the
// dp_inv output. This walks the round keys in reverse order for decryption.
// Without the macro, the controller is encrypt-only.
//
// Parameters
//   NR          number of rounds (10/12/14)
//   DP_LATENCY  cycles from dp_go to a valid dp_result (1..7)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active LOW
//   in_valid   plaintext offered         in_ready   block can be accepted
//   data_in    plaintext block
//   out_valid  ciphertext available      out_ready  consumer takes ciphertext
//   data_out   ciphertext (the running state register)
//   rk_in      round key for rnd_idx, combinational from the key store
//   rnd_idx    round-key index requested
//   dp_state   state presented to the round datapath
//   dp_go      one-cycle launch pulse for the round datapath
//   dp_last    final round (datapath skips MixColumns)
//   dp_result  round datapath output after AddRoundKey
//   busy       block in flight (RUN or DONE)
//   mode       (AES_CTRL_DECRYPT_EN) 1 = decrypt, sampled at accept
//   dp_inv     (AES_CTRL_DECRYPT_EN) registered mode, selects inverse ops
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
   parameter int NR         = 10,
   parameter int DP_LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   input  logic [127:0] rk_in,
   output logic [3:0]   rnd_idx,
   output logic [127:0] dp_state,
   output logic         dp_go,
   output logic         dp_last,
   input  logic [127:0] dp_result,
`ifdef AES_CTRL_DECRYPT_EN
   input  logic         mode,
   output logic         dp_inv,
`endif
   output logic         busy
);

   localparam logic [3:0] NR_IDX  = 4'(NR);
   localparam logic [2:0] LAT_CNT = 3'(DP_LATENCY);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t         fsm_reg,   fsm_next;
   logic [127:0] state_reg, state_next;
   logic [3:0]   round_reg, round_next;
   logic [2:0]   cnt_reg,   cnt_next;
   logic         mode_reg,  mode_next;
   // Cleared by reset and set on the first edge afterwards. This keeps
   // in_ready low for the whole reset cycle even though the FSM sits in IDLE.
   logic         ready_reg;
   logic         mode_in;
   logic [127:0] whitened;

`ifdef AES_CTRL_DECRYPT_EN
   assign mode_in = mode;
   assign dp_inv  = mode_reg;
`else
   assign mode_in = 1'b0;
`endif

   // Initial AddRoundKey applied to the incoming block, one word per lane.
   for (genvar gi = 0; gi < 4; gi++) begin : g_whiten
      assign whitened[32*gi +: 32] = data_in[32*gi +: 32] ^ rk_in[32*gi +: 32];
   end

   // Decryption consumes the key schedule back to front. Logical round r
   // therefore maps to key index NR-r.
   function automatic logic [3:0] key_idx(input logic [3:0] r, input logic inv);
      return inv ? (NR_IDX - r) : r;
   endfunction

   assign data_out = state_reg;
   assign dp_state = state_reg;

   always_comb begin
      fsm_next   = fsm_reg;
      state_next = state_reg;
      round_next = round_reg;
      cnt_next   = cnt_reg;
      mode_next  = mode_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      dp_go      = 1'b0;
      dp_last    = 1'b0;
      busy       = 1'b0;
      rnd_idx    = 4'd0;

      case (fsm_reg)
         IDLE: begin
            in_ready = ready_reg;
            // The key store must already see the whitening index in the
            // accept cycle, so the live mode input selects it here.
            rnd_idx  = key_idx(4'd0, mode_in & ready_reg);
            if (in_valid && ready_reg) begin
               state_next = whitened;
               round_next = 4'd1;
               cnt_next   = 3'd0;
               mode_next  = mode_in;
               fsm_next   = RUN;
            end
         end

         RUN: begin
            busy    = 1'b1;
            rnd_idx = key_idx(round_reg, mode_reg);
            dp_last = (round_reg == NR_IDX);
            dp_go   = (cnt_reg == 3'd0);
            if (cnt_reg == LAT_CNT) begin
               state_next = dp_result;
               cnt_next   = 3'd0;
               if (round_reg == NR_IDX) begin
                  fsm_next = DONE;
               end else begin
                  round_next = round_reg + 4'd1;
               end
            end else begin
               cnt_next = cnt_reg + 3'd1;
            end
         end

         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            rnd_idx   = key_idx(NR_IDX, mode_reg);
            // A simultaneous in_valid is not taken here. It is accepted in
            // the IDLE cycle that follows.
            if (out_ready) begin
               fsm_next = IDLE;
            end
         end

         default: begin
            fsm_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_reg   <= IDLE;
         state_reg <= '0;
         round_reg <= '0;
         cnt_reg   <= '0;
         mode_reg  <= 1'b0;
         ready_reg <= 1'b0;
      end else begin
         fsm_reg   <= fsm_next;
         state_reg <= state_next;
         round_reg <= round_next;
         cnt_reg   <= cnt_next;
         mode_reg  <= mode_next;
         ready_reg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
// ---------------------------------------------------------------------------
// Two controllers run side by side: u=0 with DP_LATENCY=1 and u=1 with
// DP_LATENCY=3. Each one has a key-store model and a round-datapath model.
// The datapath model drives its result only at the documented latency and
// drives garbage otherwise. Ciphertexts are checked against a whole-block
// AES reference (FIPS-197 cipher / inverse cipher).
// With AES_CTRL_DECRYPT_EN defined, decrypt scenarios are added.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

   localparam int NR = 10;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid [2];
   logic         in_ready [2];
   logic [127:0] data_in  [2];
   logic         out_valid[2];
   logic         out_ready[2];
   logic [127:0] data_out [2];
   logic [127:0] rk_in    [2];
   logic [3:0]   rnd_idx  [2];
   logic [127:0] dp_state [2];
   logic         dp_go    [2];
   logic         dp_last  [2];
   logic [127:0] dp_result[2];
   logic         busy     [2];
   logic         inv_w    [2];
`ifdef AES_CTRL_DECRYPT_EN
   logic         mode     [2];
   logic         dp_inv   [2];
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0]   sbox  [256];
   logic [7:0]   isbox [256];
   logic [127:0] ek [16];
   logic [127:0] dk [16];

   always #5 clk = ~clk;

   function automatic int lat_of(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   // ---------------- AES arithmetic (bench reference) ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] byt(input logic [127:0] s, input int i);
      return s[127-8*i -: 8];
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      int src;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = inv ? r + 4*((c - r + 4) % 4) : r + 4*((c + r) % 4);
            o[127-8*(r+4*c) -: 8] = inv ? isbox[byt(s, src)] : sbox[byt(s, src)];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      logic [7:0]   coef [4];
      logic [7:0]   acc;
      if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(byt(s, j+4*c), coef[(j-r+4)%4]);
            o[127-8*(r+4*c) -: 8] = acc;
         end
      end
      return o;
   endfunction

   // One pass of the external round datapath (forward or equivalent-inverse).
   function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                             input logic last, input logic inv);
      logic [127:0] t;
      t = sub_shift(s, inv);
      if (!last) t = mix(t, inv);
      return t ^ k;
   endfunction

   function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
      logic [127:0] s;
      s = pt ^ ek[0];
      for (int r = 1; r <= NR; r++) s = round_fn(s, ek[r], r == NR, 1'b0);
      return s;
   endfunction

   // Straight FIPS-197 inverse cipher (AddRoundKey before InvMixColumns).
   function automatic logic [127:0] aes_decrypt(input logic [127:0] ct);
      logic [127:0] s;
      s = ct ^ ek[NR];
      for (int r = NR - 1; r >= 0; r--) begin
         s = sub_shift(s, 1'b1) ^ ek[r];
         if (r > 0) s = mix(s, 1'b1);
      end
      return s;
   endfunction

   task automatic build_tables();
      logic [7:0] iv;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         iv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
         s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]}
                ^ {iv[3:0], iv[7:4]} ^ 8'h63;
         sbox[x]  = s;
         isbox[s] = 8'(x);
      end
   endtask

   // Key store contents: ek = cipher schedule, dk = equivalent-inverse schedule.
   task automatic expand_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++) begin
         ek[r] = '0;
         dk[r] = '0;
      end
      for (int r = 0; r <= NR; r++) begin
         ek[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         dk[r] = (r == 0 || r == NR) ? ek[r] : mix(ek[r], 1'b1);
      end
   endtask

   // ---------------- DUTs, key stores, datapath models ----------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_u
      logic [127:0] pend = '0;
      int           age  = 0;

      aes_round_ctrl #(.NR(NR), .DP_LATENCY(gi == 0 ? 1 : 3)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[gi]),
         .in_ready  (in_ready[gi]),
         .data_in   (data_in[gi]),
         .out_valid (out_valid[gi]),
         .out_ready (out_ready[gi]),
         .data_out  (data_out[gi]),
         .rk_in     (rk_in[gi]),
         .rnd_idx   (rnd_idx[gi]),
         .dp_state  (dp_state[gi]),
         .dp_go     (dp_go[gi]),
         .dp_last   (dp_last[gi]),
         .dp_result (dp_result[gi]),
`ifdef AES_CTRL_DECRYPT_EN
         .mode      (mode[gi]),
         .dp_inv    (dp_inv[gi]),
`endif
         .busy      (busy[gi])
      );

`ifdef AES_CTRL_DECRYPT_EN
      assign inv_w[gi] = dp_inv[gi];
`else
      assign inv_w[gi] = 1'b0;
`endif

      // Whitening keys (indices 0 and NR) are identical in both schedules,
      // so the registered direction is enough to pick the table.
      assign rk_in[gi] = inv_w[gi] ? dk[rnd_idx[gi]] : ek[rnd_idx[gi]];

      always @(posedge clk) begin
         if (dp_go[gi] === 1'b1) begin
            pend <= round_fn(dp_state[gi], rk_in[gi], dp_last[gi], inv_w[gi]);
            age  <= 1;
         end else if (age < 100) begin
            age  <= age + 1;
         end
      end

      assign dp_result[gi] = (age == lat_of(gi)) ? pend : ~pend;
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input int u, input logic [127:0] pt, input logic md, output bit ok);
      data_in[u]  = pt;
      in_valid[u] = 1'b1;
`ifdef AES_CTRL_DECRYPT_EN
      mode[u] = md;
`else
      if (md) $display("note: decrypt requested but feature not built");
`endif
      ok = 1'b0;
      for (int n = 0; n < 60; n++) begin
         if (in_ready[u] === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept u%0d in_ready never rose, required 1", u);
      end
   endtask

   // Called in the accept cycle; runs to the out_valid cycle and checks the
   // key order, launch spacing, final-round flag, latency and ciphertext.
   task automatic finish_block(input int u, input logic md, input logic [127:0] exp,
                               input bit keep_valid, output int lat);
      int goc;
      int last_go;
      int lastc;
      logic [3:0] want;
      lat = -1;
      goc = 0;
      last_go = 0;
      lastc = 0;
      want = md ? 4'(NR) : 4'd0;
      checks++;
      if (rnd_idx[u] !== want) begin
         errors++;
         $display("FAIL whiten_idx u%0d got %0d required %0d", u, rnd_idx[u], want);
      end
      step();
      if (!keep_valid) in_valid[u] = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         if (out_valid[u] === 1'b1) begin
            lat = k;
            break;
         end
         checks++;
         if (busy[u] !== 1'b1) begin
            errors++;
            $display("FAIL busy u%0d cycle %0d got %b required 1", u, k, busy[u]);
         end
`ifdef AES_CTRL_DECRYPT_EN
         checks++;
         if (dp_inv[u] !== md) begin
            errors++;
            $display("FAIL dp_inv u%0d cycle %0d got %b required %b", u, k, dp_inv[u], md);
         end
`endif
         if (dp_last[u] === 1'b1) lastc++;
         if (dp_go[u] === 1'b1) begin
            goc++;
            want = md ? 4'(NR - goc) : 4'(goc);
            checks++;
            if (rnd_idx[u] !== want || dp_last[u] !== (goc == NR)) begin
               errors++;
               $display("FAIL round_idx u%0d go %0d got idx %0d last %b required idx %0d last %b",
                        u, goc, rnd_idx[u], dp_last[u], want, goc == NR);
            end
            if (goc > 1) begin
               checks++;
               if (k - last_go != lat_of(u) + 1) begin
                  errors++;
                  $display("FAIL go_spacing u%0d got %0d required %0d", u, k - last_go, lat_of(u) + 1);
               end
            end
            last_go = k;
         end
         step();
      end
      checks++;
      if (lat != 1 + NR*(lat_of(u) + 1)) begin
         errors++;
         $display("FAIL latency u%0d got %0d required %0d", u, lat, 1 + NR*(lat_of(u) + 1));
      end
      checks++;
      if (goc != NR || lastc != lat_of(u) + 1) begin
         errors++;
         $display("FAIL go_count u%0d got go %0d last_cycles %0d required %0d %0d",
                  u, goc, lastc, NR, lat_of(u) + 1);
      end
      checks++;
      if (data_out[u] !== exp) begin
         errors++;
         $display("FAIL data_out u%0d got %h required %h", u, data_out[u], exp);
      end
      $display("block u%0d mode %0d lat %0d out %h", u, md, lat, data_out[u]);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      step();
      step();
      for (int u = 0; u < 2; u++) begin
         checks++;
         if (in_ready[u] !== 1'b0 || out_valid[u] !== 1'b0 || busy[u] !== 1'b0 ||
             dp_go[u] !== 1'b0 || dp_last[u] !== 1'b0 || rnd_idx[u] !== 4'd0 ||
             data_out[u] !== 128'h0) begin
            errors++;
            $display("FAIL reset_vals u%0d got rdy %b ov %b busy %b go %b last %b idx %0d out %h required all 0",
                     u, in_ready[u], out_valid[u], busy[u], dp_go[u], dp_last[u], rnd_idx[u], data_out[u]);
         end
      end
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready[0] !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge got %b required 0", in_ready[0]);
      end
      step();
      for (int u = 0; u < 2; u++) begin
         checks++;
         if (in_ready[u] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge u%0d got %b required 1", u, in_ready[u]);
         end
      end
   endtask

   task automatic test_fips();
      bit ok;
      int lat;
      offer(0, FIPS_PT, 1'b0, ok);
      finish_block(0, 1'b0, FIPS_CT, 1'b0, lat);
      checks++;
      if (lat != 21) begin
         errors++;
         $display("FAIL fips_latency got %0d required 21", lat);
      end
      step();
      checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL fips_release got ov %b rdy %b required 0 1", out_valid[0], in_ready[0]);
      end
   endtask

   task automatic test_latency_sweep();
      bit ok;
      int lat;
      offer(1, FIPS_PT, 1'b0, ok);
      finish_block(1, 1'b0, FIPS_CT, 1'b0, lat);
      checks++;
      if (lat != 41) begin
         errors++;
         $display("FAIL sweep_latency got %0d required 41", lat);
      end
      step();
   endtask

   task automatic test_backpressure();
      bit ok;
      int lat;
      logic [127:0] pt1, pt2, ct1;
      pt1 = {$urandom, $urandom, $urandom, $urandom};
      pt2 = {$urandom, $urandom, $urandom, $urandom};
      ct1 = aes_encrypt(pt1);
      out_ready[0] = 1'b0;
      offer(0, pt1, 1'b0, ok);
      finish_block(0, 1'b0, ct1, 1'b0, lat);
      data_in[0]  = pt2;
      in_valid[0] = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         checks++;
         if (out_valid[0] !== 1'b1 || data_out[0] !== ct1 || in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold cycle %0d got ov %b rdy %b out %h required 1 0 %h",
                     i, out_valid[0], in_ready[0], data_out[0], ct1);
         end
      end
      out_ready[0] = 1'b1;
      step();
      checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL hold_release got ov %b rdy %b required 0 1", out_valid[0], in_ready[0]);
      end
      finish_block(0, 1'b0, aes_encrypt(pt2), 1'b0, lat);
      step();
   endtask

   task automatic test_back_to_back();
      bit ok;
      int lat1, lat2;
      logic [127:0] a, b;
      for (int u = 0; u < 2; u++) begin
         a = {$urandom, $urandom, $urandom, $urandom};
         b = {$urandom, $urandom, $urandom, $urandom};
         out_ready[u] = 1'b1;
         offer(u, a, 1'b0, ok);
         finish_block(u, 1'b0, aes_encrypt(a), 1'b1, lat1);
         data_in[u] = b;
         step();
         checks++;
         if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap u%0d got rdy %b ov %b required 1 0", u, in_ready[u], out_valid[u]);
         end
         finish_block(u, 1'b0, aes_encrypt(b), 1'b0, lat2);
         checks++;
         if (lat2 + 1 != NR*(lat_of(u) + 1) + 2) begin
            errors++;
            $display("FAIL b2b_spacing u%0d got %0d required %0d", u, lat2 + 1, NR*(lat_of(u) + 1) + 2);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      bit hit;
      int lat;
      logic [127:0] pt;
      pt = {$urandom, $urandom, $urandom, $urandom};
      offer(0, pt, 1'b0, ok);
      step();
      in_valid[0] = 1'b0;
      hit = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (rnd_idx[0] === 4'd5) begin
            hit = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL mid_run round 5 never reached");
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || dp_go[0] !== 1'b0 || in_ready[0] !== 1'b0 ||
          rnd_idx[0] !== 4'd0 || dp_last[0] !== 1'b0 || data_out[0] !== 128'h0) begin
         errors++;
         $display("FAIL async_reset got busy %b ov %b go %b rdy %b idx %0d out %h required 0s",
                  busy[0], out_valid[0], dp_go[0], in_ready[0], rnd_idx[0], data_out[0]);
      end
      step();
      step();
      rst = 1'b1;
      step();
      pt = {$urandom, $urandom, $urandom, $urandom};
      offer(0, pt, 1'b0, ok);
      finish_block(0, 1'b0, aes_encrypt(pt), 1'b0, lat);
      step();
   endtask

`ifdef AES_CTRL_DECRYPT_EN
   task automatic test_decrypt();
      bit ok;
      int lat;
      offer(0, FIPS_CT, 1'b1, ok);
      finish_block(0, 1'b1, FIPS_PT, 1'b0, lat);
      step();
      offer(1, FIPS_CT, 1'b1, ok);
      finish_block(1, 1'b1, FIPS_PT, 1'b0, lat);
      step();
   endtask
`endif

   task automatic test_random();
      bit ok;
      int lat;
      int hold;
      logic md;
      logic [127:0] pt, exp;
      expand_key({$urandom, $urandom, $urandom, $urandom});
      for (int u = 0; u < 2; u++) begin
         for (int n = 0; n < 6; n++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_CTRL_DECRYPT_EN
            md = 1'($urandom_range(0, 1));
`else
            md = 1'b0;
`endif
            exp = md ? aes_decrypt(pt) : aes_encrypt(pt);
            out_ready[u] = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 3);
            offer(u, pt, md, ok);
            finish_block(u, md, exp, 1'b0, lat);
            if (out_ready[u] == 1'b0) begin
               for (int h = 0; h < hold; h++) begin
                  step();
                  checks++;
                  if (out_valid[u] !== 1'b1 || data_out[u] !== exp) begin
                     errors++;
                     $display("FAIL rand_hold u%0d got ov %b out %h required 1 %h",
                              u, out_valid[u], data_out[u], exp);
                  end
               end
               out_ready[u] = 1'b1;
            end
            step();
         end
      end
      expand_key(FIPS_KEY);
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         in_valid[u]  = 1'b0;
         out_ready[u] = 1'b1;
         data_in[u]   = '0;
`ifdef AES_CTRL_DECRYPT_EN
         mode[u]      = 1'b0;
`endif
      end
      build_tables();
      expand_key(FIPS_KEY);
      test_reset();
      test_fips();
      test_latency_sweep();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_run();
`ifdef AES_CTRL_DECRYPT_EN
      test_decrypt();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
